// File: rtl/avl_gpio_debounce_ctrl_if.sv
// Avalon-MM slave bus bundle for avl_gpio_debounce_ctrl.
// The Nios II side drives through the master modport; the peripheral uses slave.
interface avl_gpio_debounce_ctrl_if;
    logic        AVL_CS;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic [2:0]  AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (
        output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/avl_gpio_debounce_ctrl.sv
// Key/switch/LED peripheral: synchronised switches, debounced keys with press capture + IRQ, LED register.
// Define GPIO_RELEASE_EDGE_EN to also capture key releases in EDGE/MASK bits [2*NUM_KEYS-1:NUM_KEYS].
module avl_gpio_debounce_ctrl #(
    parameter int NUM_KEYS        = 2,
    parameter int SW_WIDTH        = 8,
    parameter int LED_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    avl_gpio_debounce_ctrl_if.slave avl,
    input  logic [NUM_KEYS-1:0]    KEY_N,
    input  logic [SW_WIDTH-1:0]    SW,
    output logic [LED_WIDTH-1:0]   LED,
    output logic                   IRQ
);

`ifdef GPIO_RELEASE_EDGE_EN
    localparam int EW = 2 * NUM_KEYS;
`else
    localparam int EW = NUM_KEYS;
`endif
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0]  key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic [SW_WIDTH-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [NUM_KEYS-1:0]  stable_q, stable_d, stable_dly_q, stable_dly_d;
    logic [CW-1:0]        cnt_q [NUM_KEYS];
    logic [CW-1:0]        cnt_d [NUM_KEYS];
    logic [EW-1:0]        cap_q, cap_d, mask_q, mask_d, evt;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_q, irq_d;

    logic                 wr_en, rd_en;
    logic [31:0]          be_mask, wdata_m;
    logic [NUM_KEYS-1:0]  pressed;
    logic                 unused_wdata;

    assign wr_en        = avl.AVL_CS & avl.AVL_WRITE;
    assign rd_en        = avl.AVL_CS & avl.AVL_READ;
    assign be_mask      = {{8{avl.AVL_BYTE_EN[3]}}, {8{avl.AVL_BYTE_EN[2]}},
                           {8{avl.AVL_BYTE_EN[1]}}, {8{avl.AVL_BYTE_EN[0]}}};
    assign wdata_m      = avl.AVL_WRITEDATA & be_mask;
    assign unused_wdata = ^{wdata_m, be_mask};
    assign pressed      = ~key_sync_q;

    always_comb begin
        key_meta_d   = KEY_N;
        key_sync_d   = key_meta_q;
        sw_meta_d    = SW;
        sw_sync_d    = sw_meta_q;
        stable_dly_d = stable_q;
    end

    // A key must disagree with its stable state for DEBOUNCE_CYCLES consecutive cycles to flip.
    always_comb begin
        stable_d = stable_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = '0;
            if (pressed[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    stable_d[k] = pressed[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        evt = '0;
        evt[NUM_KEYS-1:0] = stable_q & ~stable_dly_q;
`ifdef GPIO_RELEASE_EDGE_EN
        evt[EW-1:NUM_KEYS] = ~stable_q & stable_dly_q;
`endif
    end

    // Hardware capture is OR-ed in after the W1C so a same-cycle set survives the clear.
    always_comb begin
        cap_d  = cap_q;
        mask_d = mask_q;
        led_d  = led_q;
        if (wr_en) begin
            case (avl.AVL_ADDR)
                3'd2:    cap_d  = cap_q & ~wdata_m[EW-1:0];
                3'd3:    mask_d = (mask_q & ~be_mask[EW-1:0]) | wdata_m[EW-1:0];
                3'd4:    led_d  = (led_q & ~be_mask[LED_WIDTH-1:0]) | wdata_m[LED_WIDTH-1:0];
                3'd5:    led_d  = led_q ^ wdata_m[LED_WIDTH-1:0];
                default: ;
            endcase
        end
        cap_d = cap_d | evt;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            case (avl.AVL_ADDR)
                3'd0:    rdata_d[SW_WIDTH-1:0]  = sw_sync_q;
                3'd1:    rdata_d[NUM_KEYS-1:0]  = stable_q;
                3'd2:    rdata_d[EW-1:0]        = cap_q;
                3'd3:    rdata_d[EW-1:0]        = mask_q;
                3'd4,
                3'd5:    rdata_d[LED_WIDTH-1:0] = led_q;
                default: ;
            endcase
        end
    end

    assign irq_d = |(cap_q & mask_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_meta_q   <= '1;
            key_sync_q   <= '1;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
            cap_q        <= '0;
            mask_q       <= '0;
            led_q        <= '0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            cap_q        <= cap_d;
            mask_q       <= mask_d;
            led_q        <= led_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

    assign avl.AVL_READDATA = rdata_q;
    assign LED              = led_q;
    assign IRQ              = irq_q;

endmodule

// File: tb/tb_avl_gpio_debounce_ctrl.sv
// Bench for avl_gpio_debounce_ctrl: directed steps plus randomized traffic checked against
// a behavioural model built from sample-history windows and register-map rules.
module tb_avl_gpio_debounce_ctrl;
    localparam int NK  = 2;
    localparam int SWW = 8;
    localparam int LW  = 8;
    localparam int DC  = 4;
`ifdef GPIO_RELEASE_EDGE_EN
    localparam int          EW       = 2 * NK;
    localparam logic [31:0] EXP_PR   = 32'h5;
    localparam logic [31:0] EXP_MASK = 32'hF;
`else
    localparam int          EW       = NK;
    localparam logic [31:0] EXP_PR   = 32'h1;
    localparam logic [31:0] EXP_MASK = 32'h3;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic [NK-1:0] KEY_N;
    logic [SWW-1:0] SW;
    logic [LW-1:0] LED;
    logic          IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    avl_gpio_debounce_ctrl_if bus ();

    avl_gpio_debounce_ctrl #(
        .NUM_KEYS(NK), .SW_WIDTH(SWW), .LED_WIDTH(LW), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .CLK(CLK), .RESET(RESET), .avl(bus.slave),
        .KEY_N(KEY_N), .SW(SW), .LED(LED), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: inputs delayed 2 cycles; a key flips once its last DC samples all disagree.
    logic [NK-1:0]  m_k1, m_k2;
    logic [SWW-1:0] m_s1, m_s2;
    logic [NK-1:0]  m_stable;
    logic [DC-1:0]  m_win [NK];
    logic [EW-1:0]  m_cap, m_mask, m_pend;
    logic [LW-1:0]  m_led;
    logic [31:0]    m_rd;
    logic           m_irq;

    always @(posedge CLK) begin : model
        logic [31:0]   bm, wd, rdv;
        logic [NK-1:0] pr, rose;
`ifdef GPIO_RELEASE_EDGE_EN
        logic [NK-1:0] fell;
`endif
        if (RESET) begin
            m_k1 = '1; m_k2 = '1; m_s1 = '0; m_s2 = '0;
            m_stable = '0;
            for (int k = 0; k < NK; k++) m_win[k] = '0;
            m_cap = '0; m_mask = '0; m_pend = '0; m_led = '0; m_rd = '0; m_irq = 1'b0;
        end else begin
            bm = {{8{bus.AVL_BYTE_EN[3]}}, {8{bus.AVL_BYTE_EN[2]}},
                  {8{bus.AVL_BYTE_EN[1]}}, {8{bus.AVL_BYTE_EN[0]}}};
            wd = bus.AVL_WRITEDATA & bm;
            rdv = 32'h0;
            case (bus.AVL_ADDR)
                3'd0: rdv = 32'(m_s2);
                3'd1: rdv = 32'(m_stable);
                3'd2: rdv = 32'(m_cap);
                3'd3: rdv = 32'(m_mask);
                3'd4, 3'd5: rdv = 32'(m_led);
                default: rdv = 32'h0;
            endcase
            if (bus.AVL_CS && bus.AVL_READ) m_rd = rdv;
            m_irq = |(m_cap & m_mask);
            if (bus.AVL_CS && bus.AVL_WRITE) begin
                case (bus.AVL_ADDR)
                    3'd2: m_cap  = m_cap & ~wd[EW-1:0];
                    3'd3: m_mask = (m_mask & ~bm[EW-1:0]) | wd[EW-1:0];
                    3'd4: m_led  = (m_led & ~bm[LW-1:0]) | wd[LW-1:0];
                    3'd5: m_led  = m_led ^ wd[LW-1:0];
                    default: ;
                endcase
            end
            m_cap = m_cap | m_pend;
            pr = ~m_k2;
            rose = '0;
`ifdef GPIO_RELEASE_EDGE_EN
            fell = '0;
`endif
            for (int k = 0; k < NK; k++) begin
                m_win[k] = {m_win[k][DC-2:0], pr[k]};
                if (m_win[k] == {DC{~m_stable[k]}}) begin
                    if (!m_stable[k]) rose[k] = 1'b1;
`ifdef GPIO_RELEASE_EDGE_EN
                    else fell[k] = 1'b1;
`endif
                    m_stable[k] = ~m_stable[k];
                end
            end
            m_pend = '0;
            m_pend[NK-1:0] = rose;
`ifdef GPIO_RELEASE_EDGE_EN
            m_pend[EW-1:NK] = fell;
`endif
            m_k2 = m_k1; m_k1 = KEY_N;
            m_s2 = m_s1; m_s1 = SW;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, ".led"}, 32'(LED), 32'(m_led));
        chk({tag, ".irq"}, 32'(IRQ), 32'(m_irq));
        chk({tag, ".rdata"}, bus.AVL_READDATA, m_rd);
    endtask

    task automatic idle();
        bus.AVL_CS = 1'b0; bus.AVL_READ = 1'b0; bus.AVL_WRITE = 1'b0;
        bus.AVL_ADDR = 3'd0; bus.AVL_BYTE_EN = 4'h0; bus.AVL_WRITEDATA = 32'h0;
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_READ = 1'b0;
        bus.AVL_ADDR = a; bus.AVL_BYTE_EN = be; bus.AVL_WRITEDATA = d;
        step("wr");
        idle();
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus.AVL_CS = 1'b1; bus.AVL_READ = 1'b1; bus.AVL_WRITE = 1'b0; bus.AVL_ADDR = a;
        step(tag);
        chk(tag, bus.AVL_READDATA, exp);
        idle();
    endtask

    initial begin
        idle();
        RESET = 1'b1; KEY_N = '1; SW = 8'hA5;
        steps(2, "reset");
        chk("reset.led", 32'(LED), 32'h0);
        chk("reset.irq", 32'(IRQ), 32'h0);
        chk("reset.rdata", bus.AVL_READDATA, 32'h0);
        RESET = 1'b0;
        steps(2, "settle");
        for (int a = 0; a < 8; a++) rd_chk(3'(a), (a == 0) ? 32'hA5 : 32'h0, "map");

        // Short glitch, then a real press.
        KEY_N = 2'b10; steps(3, "glitch");
        KEY_N = 2'b11; steps(8, "glitch");
        rd_chk(3'd1, 32'h0, "glitch.key");
        rd_chk(3'd2, 32'h0, "glitch.edge");
        KEY_N = 2'b10; steps(10, "press");
        rd_chk(3'd1, 32'h1, "press.key");
        rd_chk(3'd2, 32'h1, "press.edge");
        wr(3'd2, 32'hF, 4'hF);

        // Interrupt set/clear and W1C racing a hardware set.
        wr(3'd3, 32'h1, 4'hF);
        KEY_N = 2'b11; steps(10, "rel");
        wr(3'd2, 32'hF, 4'hF);
        KEY_N = 2'b10; steps(10, "irqpress");
        chk("irq.set", 32'(IRQ), 32'h1);
        wr(3'd2, 32'h1, 4'hF);
        chk("irq.lag", 32'(IRQ), 32'h1);
        step("irqclr");
        chk("irq.clr", 32'(IRQ), 32'h0);
        KEY_N = 2'b11; steps(10, "rel2");
        wr(3'd2, 32'hF, 4'hF);
        KEY_N = 2'b10; steps(6, "race");
        wr(3'd2, 32'h1, 4'hF);
        rd_chk(3'd2, 32'h1, "race.edge");
        chk("race.irq", 32'(IRQ), 32'h1);

        // LED write with byte enables and toggle.
        wr(3'd4, 32'hFFFF_FF0F, 4'b0001);
        chk("led.write", 32'(LED), 32'h0F);
        wr(3'd5, 32'hFF, 4'hF);
        chk("led.toggle", 32'(LED), 32'hF0);
        wr(3'd5, 32'hFF, 4'h0);
        chk("led.noben", 32'(LED), 32'hF0);
        rd_chk(3'd5, 32'hF0, "led.rdtoggle");

        // Reset in the middle of a key1 debounce.
        KEY_N = 2'b11; steps(10, "rel3");
        KEY_N = 2'b01; steps(4, "mid");
        RESET = 1'b1; step("midrst");
        RESET = 1'b0;
        rd_chk(3'd1, 32'h0, "rst.key0");
        steps(4, "rst.wait");
        rd_chk(3'd1, 32'h0, "rst.key1");
        rd_chk(3'd1, 32'h2, "rst.key2");
        chk("rst.led", 32'(LED), 32'h0);

        // Press/release capture and mask width.
        KEY_N = 2'b11; steps(10, "rel4");
        wr(3'd2, 32'hF, 4'hF);
        KEY_N = 2'b10; steps(10, "pr.press");
        KEY_N = 2'b11; steps(10, "pr.release");
        rd_chk(3'd2, EXP_PR, "pr.edge");
        wr(3'd3, 32'hF, 4'hF);
        rd_chk(3'd3, EXP_MASK, "pr.mask");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NK; k++) if ($urandom_range(5) == 0) KEY_N[k] = ~KEY_N[k];
            if ($urandom_range(15) == 0) SW = 8'($urandom);
            bus.AVL_CS        = 1'($urandom_range(3) != 0);
            bus.AVL_READ      = 1'($urandom_range(1));
            bus.AVL_WRITE     = 1'($urandom_range(2) == 0);
            bus.AVL_ADDR      = 3'($urandom);
            bus.AVL_BYTE_EN   = 4'($urandom);
            bus.AVL_WRITEDATA = $urandom;
            step("rnd");
        end
        idle();
        for (int a = 0; a < 8; a++) begin
            bus.AVL_CS = 1'b1; bus.AVL_READ = 1'b1; bus.AVL_ADDR = 3'(a);
            step("final");
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
